// File: rtl/ysyx_22041412_cache_pkg.sv
// Shared line geometry and FSM state encoding for the ysyx_22041412 instruction cache.
package ysyx_22041412_cache_pkg;

    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = 4;
    localparam int LINE_W     = LINE_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_AR,
        REFILL_R,
        RESP
    } state_e;

endpackage

// File: rtl/ysyx_22041412_icache_array.sv
// Direct-mapped valid/tag/data storage with one shared read/write index.
module ysyx_22041412_icache_array
    import ysyx_22041412_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 32 - OFFSET_W - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inv_all,
    input  logic [IDX_W-1:0]  idx,
    input  logic              we,
    input  logic [TAG_W-1:0]  wtag,
    input  logic [LINE_W-1:0] wdata,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [LINE_W-1:0] lines [LINES];

    // Only the valid bits are reset; tag and data contents are don't-care until validated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (inv_all) begin
            valid <= '0;
        end else if (we) begin
            valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[idx]  <= wtag;
            lines[idx] <= wdata;
        end
    end

    assign rd_valid = valid[idx];
    assign rd_tag   = tags[idx];
    assign rd_data  = lines[idx];

endmodule

// File: rtl/ysyx_22041412_icache.sv
// Blocking direct-mapped I-cache returning whole 128-bit lines, refilled as 64-bit beats.
// Define YSYX_22041412_ICACHE_PERF_EN to build the 64-bit hit/miss counters.
module ysyx_22041412_icache
    import ysyx_22041412_cache_pkg::*;
#(
    parameter int LINES     = 16,
    parameter int MEM_BEATS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [31:0]       r_addr_i,
    output logic              ready_o,
    output logic [LINE_W-1:0] r_data_o,
    input  logic              fence_i,
    output logic              mem_ar_valid_o,
    input  logic              mem_ar_ready_i,
    output logic [31:0]       mem_ar_addr_o,
    input  logic              mem_r_valid_i,
    input  logic [63:0]       mem_r_data_i,
    output logic [63:0]       hit_cnt_o,
    output logic [63:0]       miss_cnt_o
);

    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 32 - OFFSET_W - IDX_W;
    localparam int BEAT_W = $clog2(MEM_BEATS);

    state_e               state_q, state_d;
    logic [31:OFFSET_W]   addr_q;
    logic [BEAT_W-1:0]    beat_q;
    logic                 fence_pend;
    logic [63:0]          line_lo;
    logic [LINE_W-1:0]    resp_q;

    logic                 fence_clr, refill_we, accept, hit, last_beat;
    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_W-1:0]    rd_data;
    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic                 unused_offset;

    assign unused_offset = ^r_addr_i[OFFSET_W-1:0];
    assign idx       = addr_q[OFFSET_W+IDX_W-1:OFFSET_W];
    assign tag       = addr_q[31:OFFSET_W+IDX_W];
    assign hit       = rd_valid && (rd_tag == tag);
    assign last_beat = (beat_q == BEAT_W'(MEM_BEATS - 1));

    ysyx_22041412_icache_array #(.LINES(LINES)) u_array (
        .clk      (clk),
        .rst      (rst),
        .inv_all  (fence_clr),
        .idx      (idx),
        .we       (refill_we),
        .wtag     (tag),
        .wdata    ({mem_r_data_i, line_lo}),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // A pending or fresh fence is applied in IDLE before any new request is taken.
    always_comb begin
        state_d        = state_q;
        fence_clr      = 1'b0;
        refill_we      = 1'b0;
        accept         = 1'b0;
        ready_o        = 1'b0;
        mem_ar_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (fence_i || fence_pend) begin
                    fence_clr = 1'b1;
                end else if (valid_i) begin
                    accept  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP:    state_d = hit ? RESP : REFILL_AR;
            REFILL_AR: begin
                mem_ar_valid_o = 1'b1;
                if (mem_ar_ready_i) state_d = REFILL_R;
            end
            REFILL_R: begin
                if (mem_r_valid_i && last_beat) begin
                    refill_we = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                ready_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            beat_q     <= '0;
            fence_pend <= 1'b0;
        end else begin
            if (accept) addr_q <= r_addr_i[31:OFFSET_W];
            if (state_q == REFILL_R && mem_r_valid_i)
                beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
            if (fence_clr)    fence_pend <= 1'b0;
            else if (fence_i) fence_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == REFILL_R && mem_r_valid_i && beat_q == '0) line_lo <= mem_r_data_i;
        if (state_q == LOOKUP && hit) resp_q <= rd_data;
        else if (refill_we)           resp_q <= {mem_r_data_i, line_lo};
    end

    assign r_data_o      = resp_q;
    assign mem_ar_addr_o = {addr_q, {OFFSET_W{1'b0}}};

`ifdef YSYX_22041412_ICACHE_PERF_EN
    logic [63:0] hit_cnt, miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit) hit_cnt  <= hit_cnt + 64'd1;
            else     miss_cnt <= miss_cnt + 64'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: doc/ysyx_22041412_icache.md
YSYX_22041412_ICACHE -- requirements
Module: ysyx_22041412_icache

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped lines (power of two, >=2).
REQ-002 SHALL have parameter MEM_BEATS, fixed 2, 64-bit memory beats per 128-bit line.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port valid_i  input  1  fetch request from IF, held until ready_o seen.
REQ-006 SHALL have port r_addr_i  input  32  fetch byte address, stable while valid_i high.
REQ-007 SHALL have port ready_o  output  1  one-cycle response strobe, r_data_o valid.
REQ-008 SHALL have port r_data_o  output  128  full 16-byte line containing r_addr_i.
REQ-009 SHALL have port fence_i  input  1  invalidate-all request (fence.i).
REQ-010 SHALL have ports mem_ar_valid_o output 1, mem_ar_ready_i input 1, mem_ar_addr_o output 32 (line-aligned refill address).
REQ-011 SHALL have ports mem_r_valid_i input 1, mem_r_data_i input 64 (refill beat).
REQ-012 SHALL have ports hit_cnt_o output 64, miss_cnt_o output 64 (performance counters).

Function
REQ-013 SHALL decode address as offset [3:0] (ignored for lookup), index [3+log2(LINES):4], tag = remaining upper bits.
REQ-014 SHALL implement states IDLE, LOOKUP, REFILL_AR, REFILL_R, RESP.
REQ-015 IDLE: valid_i high and no fence pending -> latch r_addr_i, go LOOKUP.
REQ-016 LOOKUP: valid and tag match -> RESP with stored line; else REFILL_AR.
REQ-017 REFILL_AR: mem_ar_valid_o=1, mem_ar_addr_o={addr[31:4],4'b0}, held until mem_ar_ready_i; then REFILL_R.
REQ-018 REFILL_R: beat 0 -> line[63:0], beat 1 -> line[127:64]; cache counts beats itself; on beat 1 write data, tag, valid bit, go RESP.
REQ-019 RESP: ready_o=1 exactly one cycle with r_data_o = hit or refilled line, then IDLE.
REQ-020 Hit latency SHALL be 2 cycles from first sampled valid_i to ready_o; miss latency = 2 + AR wait + beat arrival + 1.
REQ-021 ready_o SHALL be 0 outside RESP; r_data_o value undefined outside RESP.
REQ-022 Requester drops valid_i at the edge after ready_o; IDLE SHALL never reaccept the same request in the cycle after RESP.
REQ-023 fence_i in IDLE SHALL clear all valid bits in one cycle, taking priority over a simultaneous valid_i (request accepted next cycle).
REQ-024 fence_i while busy SHALL set a pending flag, applied on next IDLE cycle before any lookup; the in-flight response SHALL still complete.
REQ-025 mem_r_valid_i outside REFILL_R SHALL be ignored.

Reset
REQ-026 On rst low: state IDLE, all valid bits 0, fence-pending 0, beat counter 0, ready_o 0, mem_ar_valid_o 0, mem_ar_addr_o 0, counters 0.
REQ-027 Data/tag arrays SHALL NOT be reset.
REQ-028 Reset mid-refill SHALL abandon the refill and leave the line invalid.

Configuration
REQ-029 Macro YSYX_22041412_ICACHE_PERF_EN defined: hit_cnt_o increments on each LOOKUP hit, miss_cnt_o on each LOOKUP miss, wrap modulo 2^64.
REQ-030 Macro undefined: no counter registers; hit_cnt_o and miss_cnt_o tied to 0.

Structure
REQ-031 Package ysyx_22041412_cache_pkg SHALL hold LINE_BYTES=16, OFFSET_W=4, state encoding typedef.
REQ-032 Storage (valid, tag, data arrays, single read/write port) SHALL be sub-module ysyx_22041412_icache_array.

Verification
REQ-033 Cold miss: valid_i, addr 0x80000000, memory beats 0x00000013_00000413 then 0x00100073_00000093 -> mem_ar_addr_o 0x80000000, ready_o, r_data_o 0x00100073_00000093_00000013_00000413.
REQ-034 Hit: then addr 0x80000008 -> ready_o exactly 2 cycles after valid_i, no mem_ar_valid_o, same line.
REQ-035 Conflict (LINES=16): addr 0x80000100 evicts index 0; re-fetch 0x80000000 -> refill again, miss_cnt_o=3 with PERF_EN.
REQ-036 Fence: fence_i with valid_i same cycle in IDLE, addr 0x80000000 cached -> request served as miss.
REQ-037 Backpressure: mem_ar_ready_i low 5 cycles -> mem_ar_valid_o and mem_ar_addr_o stable 5 cycles, no ready_o.
REQ-038 Reset mid-refill after beat 0 -> outputs at reset values; subsequent fetch same address misses.
